gemm_result_collector: RTL and testbench
========================================

# gemm_result_collector

Result-side counterpart of the DA GEMM array: watches the array's bit-serial sequencing (`gen_done`), captures the per-column `final_out[N]` vector each time a kernel row completes its DATA_WIDTH_A-cycle pass, and applies optional ReLU plus saturation. It assembles M rows into a ping-pong tile buffer and streams finished tiles downstream, one row per beat, under a valid/ready handshake. It back-pressures the array through `stall`.

## Interface
- DATA_WIDTH_A, 8, kernel bit width; sets cycles per row pass
- DATA_WIDTH_output, 8, width of incoming `final_out` elements (signed)
- OUT_WIDTH, 8, width of emitted elements (signed, ≤ DATA_WIDTH_output)
- M, 2, rows per tile
- N, 4, columns per row
- RELU_EN, 1, 1 = clamp negatives to 0 before saturation
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- gen_done  in  1  array step enable, same signal that drives the array
- final_out  in  signed [DATA_WIDTH_output-1:0] ×[N]  array result vector
- stall  out  1  request to array to drop `gen_done`
- out_valid  out  1  row beat valid
- out_ready  in  1  downstream accept
- out_data  out  signed [OUT_WIDTH-1:0] ×[N]  processed row
- out_row  out  $clog2(M) (min 1)  row index within tile
- out_last  out  1  high on row M-1 beat
- overflow  out  1  sticky: a row was dropped

## Operation
- Mirror counter `t` (0..DATA_WIDTH_A-1): increments on each `gen_done` cycle. Wrap occurs on `gen_done` with t = DATA_WIDTH_A-1.
- `cap` = registered wrap. On `cap`, sample `final_out`, process it, and write it into the fill bank at `fill_row`. Then increment `fill_row`.
- Processing per element:
  - if RELU_EN and value < 0 → 0;
  - then saturate to OUT_WIDTH: > 2^(OUT_WIDTH-1)-1 → max, < -2^(OUT_WIDTH-1) → min.
- Fill bank completes when `fill_row` reaches M.
  - Drain bank empty → swap banks in the same cycle, start DRAIN, set `fill_row` = 0.
  - Otherwise the fill bank becomes FULL and holds.
- Drain FSM: IDLE → DRAIN on swap. In DRAIN, `out_valid` = 1 and row data is presented. A beat transfers when `out_valid & out_ready`.
  - Transfer on `out_row` = M-1 → IDLE.
  - If the fill bank is FULL at that point → immediate swap and stay in DRAIN, with row 0 of the new tile next cycle.
- `stall` = fill bank FULL, or (`fill_row` = M-1 and drain not IDLE).
- `cap` while fill bank FULL → row dropped and `overflow` ← 1; the counters are unchanged.
- `out_data`, `out_row` and `out_last` are stable while `out_valid` & !`out_ready`.
- Reset (asynchronous, also mid-tile): t = 0, `fill_row` = 0, both banks empty, FSM IDLE. All outputs 0: `stall`, `out_valid`, `out_data`, `out_row`, `out_last`, `overflow`. Partial tiles are discarded.

## Timing
- Capture latency: one cycle after the wrap edge. `final_out` must be valid on the cycle following the wrap edge, which is the array's t = 0 cycle.
- Row M-1 capture to first `out_valid`: 1 cycle when the drain bank is free.
- Drain throughput: 1 row/cycle with `out_ready` held high. Back-to-back tiles have no bubble.
- `stall` is registered-free (combinational from state). The array must deassert `gen_done` in the next cycle.
- Simultaneous `cap` of the last row and drain of the last beat: the swap succeeds, no FULL, no stall.

## Structure
- Package `gemm_pkg`: drain-state enum, and a `sat_relu` function (ReLU plus saturation, parameterised by widths). The same function is shared with other post-processing blocks.
- Sub-module `tile_bank` (M×N register array with write port and row read port), instantiated twice.
- Optional `gemm_result_collector_top` wrapper, pairing with the array, for system benches.

## Test plan
- M=2, N=4, DATA_WIDTH_A=8; 16 `gen_done` cycles with `final_out` = {1,-2,3,-4} at capture 0 and {100,-100,127,-128} at capture 1, `out_ready` = 1:
  - RELU_EN=0 → beats {1,-2,3,-4} row 0, then {100,-100,127,-128} row 1 with `out_last`.
  - RELU_EN=1 → {1,0,3,0}, {100,0,127,0}.
- DATA_WIDTH_output=16, OUT_WIDTH=8, RELU_EN=0, values {300,-300,127,-129} → {127,-128,127,-128}.
- `out_ready` = 0 while 2 tiles are captured → `stall` rises at the second tile's row M-1 and stays high. Raise `out_ready` → 4 beats in 4 cycles, `stall` falls after the first tile drains.
- Ignore `stall` and keep `gen_done` high through a 5th row → `overflow` = 1, dropped row never emitted, the 4 buffered rows intact.
- Assert `rst_n` = 0 mid-pass (t = 3) and mid-drain → all outputs 0 immediately. After release, the first capture occurs after exactly 8 `gen_done` cycles.
- Random `out_ready` toggling over 50 tiles → output stream matches the scoreboard and holds stable during stalls.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GEMM result post-processing blocks.
package gemm_pkg;

  // Drain-side sequencing of the ping-pong tile buffer.
  typedef enum logic [0:0] {
    DrainIdle,
    DrainRun
  } drain_state_e;

  // ReLU (optional) followed by signed saturation to out_w bits.
  // Operates on a 32-bit signed value; callers keep the low out_w bits.
  function automatic logic signed [31:0] sat_relu(input logic signed [31:0] v,
                                                  input int unsigned      out_w,
                                                  input bit               relu_en);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] r;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    r  = v;
    if (relu_en && (r < 32'sd0)) r = 32'sd0;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/tile_bank.sv
// One M x N tile of processed results: single row write port, single row read port.
module tile_bank #(
  parameter int unsigned M  = 2,
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned RW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [RW-1:0]         waddr,
  input  logic [N-1:0][W-1:0]   wdata,
  input  logic [RW-1:0]         raddr,
  output logic [N-1:0][W-1:0]   rdata
);

  logic [N-1:0][W-1:0] mem_q [M];

  // Row storage; cleared on reset so a discarded partial tile never reappears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(M); r++) mem_q[r] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/gemm_result_collector.sv
// Captures array result rows, applies ReLU/saturation, buffers M-row tiles in a
// ping-pong pair of banks and streams finished tiles out one row per beat.
module gemm_result_collector
  import gemm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_A      = 8,
  parameter int unsigned DATA_WIDTH_output = 8,
  parameter int unsigned OUT_WIDTH         = 8,
  parameter int unsigned M                 = 2,
  parameter int unsigned N                 = 4,
  parameter bit          RELU_EN           = 1'b1,
  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1,
  localparam int unsigned TW = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                gen_done,
  input  logic signed [DATA_WIDTH_output-1:0] final_out [N],
  output logic                                stall,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUT_WIDTH-1:0]         out_data [N],
  output logic [RW-1:0]                       out_row,
  output logic                                out_last,
  output logic                                overflow
);

  logic [TW-1:0] t_q, t_d;
  logic          cap_q;
  logic [RW-1:0] fill_row_q, fill_row_d;
  logic          fill_sel_q, fill_sel_d;   // bank currently being filled
  logic          fill_full_q, fill_full_d;
  logic [RW-1:0] drain_row_q, drain_row_d;
  logic          overflow_q, overflow_d;
  drain_state_e  drain_st_q, drain_st_d;

  logic wrap, beat, last_beat, cap_ok, row_done;
  logic [N-1:0][OUT_WIDTH-1:0] wdata, rdata0, rdata1, rd;
  logic signed [31:0] ext [N];
  logic signed [31:0] proc [N];

  assign wrap      = gen_done && (t_q == TW'(DATA_WIDTH_A - 1));
  assign beat      = (drain_st_q == DrainRun) && out_ready;
  assign last_beat = beat && (drain_row_q == RW'(M - 1));
  assign cap_ok    = cap_q && !fill_full_q;
  assign row_done  = cap_ok && (fill_row_q == RW'(M - 1));

  // Element-wise ReLU + saturation of the sampled array vector.
  always_comb begin
    for (int c = 0; c < int'(N); c++) begin
      ext[c]   = 32'(final_out[c]);
      proc[c]  = sat_relu(ext[c], OUT_WIDTH, RELU_EN);
      wdata[c] = proc[c][OUT_WIDTH-1:0];
    end
  end

  // Mirror of the array's bit-serial step counter plus the registered capture strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q   <= '0;
      cap_q <= 1'b0;
    end else begin
      t_q   <= t_d;
      cap_q <= wrap;
    end
  end

  // Fill/drain bookkeeping and drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_row_q  <= '0;
      fill_sel_q  <= 1'b0;
      fill_full_q <= 1'b0;
      drain_row_q <= '0;
      overflow_q  <= 1'b0;
      drain_st_q  <= DrainIdle;
    end else begin
      fill_row_q  <= fill_row_d;
      fill_sel_q  <= fill_sel_d;
      fill_full_q <= fill_full_d;
      drain_row_q <= drain_row_d;
      overflow_q  <= overflow_d;
      drain_st_q  <= drain_st_d;
    end
  end

  // Next-state: step counter, row fill, bank swap and drain sequencing.
  always_comb begin
    t_d         = t_q;
    fill_row_d  = fill_row_q;
    fill_sel_d  = fill_sel_q;
    fill_full_d = fill_full_q;
    drain_row_d = drain_row_q;
    overflow_d  = overflow_q;
    drain_st_d  = drain_st_q;

    if (gen_done) t_d = wrap ? '0 : t_q + TW'(1);

    // A capture with a full tile already waiting has nowhere to go.
    if (cap_q && fill_full_q) overflow_d = 1'b1;

    if (beat) drain_row_d = drain_row_q + RW'(1);
    if (last_beat) begin
      drain_st_d  = DrainIdle;
      drain_row_d = '0;
      if (fill_full_q) begin
        fill_sel_d  = ~fill_sel_q;
        fill_full_d = 1'b0;
        drain_st_d  = DrainRun;
      end
    end

    if (cap_ok) fill_row_d = fill_row_q + RW'(1);
    // fill_full_q is low here, so this never collides with the swap above.
    if (row_done) begin
      fill_row_d = '0;
      if ((drain_st_q == DrainIdle) || last_beat) begin
        fill_sel_d  = ~fill_sel_q;
        drain_st_d  = DrainRun;
        drain_row_d = '0;
      end else begin
        fill_full_d = 1'b1;
      end
    end
  end

  tile_bank #(
    .M (M),
    .N (N),
    .W (OUT_WIDTH),
    .RW(RW)
  ) u_bank0 (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (cap_ok && !fill_sel_q),
    .waddr(fill_row_q),
    .wdata(wdata),
    .raddr(drain_row_q),
    .rdata(rdata0)
  );

  tile_bank #(
    .M (M),
    .N (N),
    .W (OUT_WIDTH),
    .RW(RW)
  ) u_bank1 (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (cap_ok && fill_sel_q),
    .waddr(fill_row_q),
    .wdata(wdata),
    .raddr(drain_row_q),
    .rdata(rdata1)
  );

  assign rd = fill_sel_q ? rdata0 : rdata1;

  assign stall     = fill_full_q || ((fill_row_q == RW'(M - 1)) && (drain_st_q != DrainIdle));
  assign out_valid = (drain_st_q == DrainRun);
  assign out_row   = drain_row_q;
  assign out_last  = out_valid && (drain_row_q == RW'(M - 1));
  assign overflow  = overflow_q;

  // Row beat data, forced to zero whenever no beat is presented.
  always_comb begin
    for (int c = 0; c < int'(N); c++) begin
      out_data[c] = out_valid ? rd[c] : '0;
    end
  end

endmodule

// File: tb/tb_gemm_result_collector.sv
// Bench for gemm_result_collector: two instances (ReLU off/on) share stimulus and are
// checked every cycle against a row-queue reference model.
module tb_gemm_result_collector;

  localparam int unsigned DWA = 8;
  localparam int unsigned DWO = 16;
  localparam int unsigned OW  = 8;
  localparam int unsigned M   = 2;
  localparam int unsigned N   = 4;
  localparam int unsigned RW  = 1;

  typedef logic [N-1:0][OW-1:0] row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gen_done = 1'b0;
  logic out_ready = 1'b0;
  logic signed [DWO-1:0] final_out [N];

  logic stall_p, valid_p, last_p, ovf_p;
  logic stall_r, valid_r, last_r, ovf_r;
  logic [RW-1:0] row_p, row_r;
  logic signed [OW-1:0] data_p [N];
  logic signed [OW-1:0] data_r [N];

  always #5 clk = ~clk;

  gemm_result_collector #(
    .DATA_WIDTH_A(DWA), .DATA_WIDTH_output(DWO), .OUT_WIDTH(OW), .M(M), .N(N), .RELU_EN(1'b0)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .gen_done(gen_done), .final_out(final_out), .stall(stall_p),
    .out_valid(valid_p), .out_ready(out_ready), .out_data(data_p), .out_row(row_p),
    .out_last(last_p), .overflow(ovf_p)
  );

  gemm_result_collector #(
    .DATA_WIDTH_A(DWA), .DATA_WIDTH_output(DWO), .OUT_WIDTH(OW), .M(M), .N(N), .RELU_EN(1'b1)
  ) dut_r (
    .clk(clk), .rst_n(rst_n), .gen_done(gen_done), .final_out(final_out), .stall(stall_r),
    .out_valid(valid_r), .out_ready(out_ready), .out_data(data_r), .out_row(row_r),
    .out_last(last_r), .overflow(ovf_r)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: completed rows waiting to be emitted, the tile being assembled,
  // a count of gen_done cycles (every DWA-th one triggers a capture next cycle).
  row_t exp_p_q[$];
  row_t exp_r_q[$];
  row_t part_p_q[$];
  row_t part_r_q[$];
  int   gd_cnt = 0;
  bit   cap_pend = 1'b0;
  bit   ovf_exp = 1'b0;
  int   rows_out = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] proc(input int v, input bit relu);
    int r;
    int hi;
    int lo;
    hi = (1 << (OW - 1)) - 1;
    lo = -(1 << (OW - 1));
    r = v;
    if (relu && r < 0) r = 0;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r[OW-1:0];
  endfunction

  function automatic row_t pack(input logic signed [OW-1:0] d [N]);
    row_t r;
    for (int c = 0; c < int'(N); c++) r[c] = d[c];
    return r;
  endfunction

  task automatic model_reset();
    exp_p_q.delete();
    exp_r_q.delete();
    part_p_q.delete();
    part_r_q.delete();
    gd_cnt   = 0;
    cap_pend = 1'b0;
    ovf_exp  = 1'b0;
  endtask

  task automatic check_cycle();
    int sz;
    int tiles;
    int idx;
    bit v;
    bit st;
    sz    = exp_p_q.size();
    tiles = (sz + int'(M) - 1) / int'(M);
    idx   = (int'(M) - (sz % int'(M))) % int'(M);
    v     = (sz > 0);
    st    = (tiles == 2) || ((part_p_q.size() == int'(M) - 1) && (tiles >= 1));
    chk("valid_p", 64'(valid_p), 64'(v));
    chk("valid_r", 64'(valid_r), 64'(v));
    chk("stall_p", 64'(stall_p), 64'(st));
    chk("stall_r", 64'(stall_r), 64'(st));
    chk("overflow_p", 64'(ovf_p), 64'(ovf_exp));
    chk("overflow_r", 64'(ovf_r), 64'(ovf_exp));
    if (v) begin
      chk("data_p", 64'(pack(data_p)), 64'(exp_p_q[0]));
      chk("data_r", 64'(pack(data_r)), 64'(exp_r_q[0]));
      chk("row_p", 64'(row_p), 64'(idx));
      chk("row_r", 64'(row_r), 64'(idx));
      chk("last_p", 64'(last_p), 64'(idx == int'(M) - 1));
      chk("last_r", 64'(last_r), 64'(idx == int'(M) - 1));
    end
  endtask

  task automatic model_step();
    bit   beat;
    int   tiles;
    row_t rp;
    row_t rr;
    beat  = (exp_p_q.size() > 0) && out_ready;
    tiles = (exp_p_q.size() + int'(M) - 1) / int'(M);
    if (cap_pend) begin
      if (tiles == 2) begin
        ovf_exp = 1'b1;
      end else begin
        for (int c = 0; c < int'(N); c++) begin
          rp[c] = proc(int'(final_out[c]), 1'b0);
          rr[c] = proc(int'(final_out[c]), 1'b1);
        end
        part_p_q.push_back(rp);
        part_r_q.push_back(rr);
        if (part_p_q.size() == int'(M)) begin
          foreach (part_p_q[i]) exp_p_q.push_back(part_p_q[i]);
          foreach (part_r_q[i]) exp_r_q.push_back(part_r_q[i]);
          part_p_q.delete();
          part_r_q.delete();
        end
      end
    end
    if (beat) begin
      void'(exp_p_q.pop_front());
      void'(exp_r_q.pop_front());
      rows_out++;
    end
    cap_pend = gen_done && ((gd_cnt % int'(DWA)) == int'(DWA) - 1);
    if (gen_done) gd_cnt++;
  endtask

  // One clock: drive, check at the falling edge, advance the model, resume after the rise.
  task automatic step(input bit gd, input bit rdy);
    gen_done  = gd;
    out_ready = rdy;
    @(negedge clk);
    check_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fo(input int a, input int b, input int c, input int d);
    final_out[0] = DWO'(a);
    final_out[1] = DWO'(b);
    final_out[2] = DWO'(c);
    final_out[3] = DWO'(d);
  endtask

  // One full pass of gen_done, then present the vector the following capture will sample.
  task automatic feed(input int a, input int b, input int c, input int d, input bit rdy);
    repeat (DWA) step(1'b1, rdy);
    set_fo(a, b, c, d);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid_p | valid_r), 64'(0));
    chk({tag, "_stall"}, 64'(stall_p | stall_r), 64'(0));
    chk({tag, "_ovf"}, 64'(ovf_p | ovf_r), 64'(0));
    chk({tag, "_row"}, 64'(row_p | row_r), 64'(0));
    chk({tag, "_last"}, 64'(last_p | last_r), 64'(0));
    chk({tag, "_data_p"}, 64'(pack(data_p)), 64'(0));
    chk({tag, "_data_r"}, 64'(pack(data_r)), 64'(0));
  endtask

  initial begin
    int base;
    int target;
    set_fo(0, 0, 0, 0);

    // Reset state.
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Basic two-row tile with ReLU off/on.
    feed(1, -2, 3, -4, 1'b1);
    feed(100, -100, 127, -128, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    chk("basic_rows", 64'(rows_out), 64'(2));

    // Saturation of wide inputs.
    feed(300, -300, 127, -129, 1'b1);
    feed(-1, 0, -32768, 32767, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    chk("sat_rows", 64'(rows_out), 64'(4));

    // Back-pressure: two tiles buffered, a fifth row dropped, then drain.
    feed(11, 12, 13, 14, 1'b0);
    feed(21, 22, 23, 24, 1'b0);
    feed(31, 32, 33, 34, 1'b0);
    feed(41, 42, 43, 44, 1'b0);
    feed(51, 52, 53, 54, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    chk("bp_stall", 64'(stall_p), 64'(1));
    chk("bp_overflow", 64'(ovf_p), 64'(1));
    base = rows_out;
    repeat (4) step(1'b0, 1'b1);
    chk("bp_four_beats", 64'(rows_out - base), 64'(4));
    repeat (2) step(1'b0, 1'b1);

    // Asynchronous reset mid-drain and mid-pass (t = 3).
    feed(5, 6, 7, 8, 1'b0);
    feed(9, 10, 11, 12, 1'b0);
    step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    gen_done = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    feed(-7, 70, -70, 7, 1'b1);
    feed(1, 2, 3, 4, 1'b1);
    repeat (4) step(1'b0, 1'b1);

    // Random gen_done / out_ready traffic over at least 50 tiles.
    base   = rows_out;
    target = base + 50 * int'(M);
    for (int cyc = 0; cyc < 20000 && rows_out < target; cyc++) begin
      for (int c = 0; c < int'(N); c++) begin
        if ($urandom_range(0, 1) == 0) final_out[c] = DWO'($urandom_range(0, 600) - 300);
        else final_out[c] = DWO'($urandom);
      end
      step(!stall_p && ($urandom_range(0, 3) != 0), $urandom_range(0, 2) != 0);
    end
    chk("random_progress", 64'(rows_out >= target), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
